// File: rtl/fft_sequencer_if.sv
// Handshake and memory-control bundle between the top-level controller,
// the FFT sequencer and the sample memory / butterfly datapath.
// Optional FFT_INVERSE_EN adds the 'inverse' request bit.
interface fft_sequencer_if;
  logic       start;
  logic       stall;
`ifdef FFT_INVERSE_EN
  logic       inverse;
`endif
  logic       busy;
  logic       done;
  logic [1:0] stage;
  logic       issue_valid;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [2:0] twiddle_select;
  logic       wr_valid;
  logic [2:0] wr_addr_a;
  logic [2:0] wr_addr_b;

  // Controller side: requests a transform and watches progress.
  modport master (
`ifdef FFT_INVERSE_EN
    output inverse,
`endif
    output start, stall,
    input  busy, done, stage, issue_valid, rd_addr_a, rd_addr_b,
    input  twiddle_select, wr_valid, wr_addr_a, wr_addr_b
  );

  // Sequencer side.
  modport slave (
`ifdef FFT_INVERSE_EN
    input  inverse,
`endif
    input  start, stall,
    output busy, done, stage, issue_valid, rd_addr_a, rd_addr_b,
    output twiddle_select, wr_valid, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_sequencer.sv
// Control sequencer for an 8-point radix-2 DIT FFT: walks 3 stages x 4
// butterflies, issues operand read addresses plus twiddle code, and replays
// the addresses as in-place write-backs BUTTERFLY_LATENCY cycles later.
// Optional macro FFT_INVERSE_EN: latches 'inverse' at start and emits
// conjugate twiddle codes ((8-k) mod 8) when it is set.
module fft_sequencer #(
  parameter int BUTTERFLY_LATENCY = 2  // legal range 1..7
) (
  input logic           clk,
  input logic           nReset,
  fft_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(BUTTERFLY_LATENCY - 1);

  state_t     state_reg;
  logic [1:0] s_reg;
  logic [1:0] b_reg;
  logic [2:0] drain_cnt_reg;
`ifdef FFT_INVERSE_EN
  logic       inverse_reg;
`endif

  logic       busy_reg;
  logic       done_reg;
  logic [1:0] stage_reg;
  logic       issue_valid_reg;
  logic [2:0] rd_a_reg;
  logic [2:0] rd_b_reg;
  logic [2:0] tw_reg;

  logic       pipe_valid [BUTTERFLY_LATENCY];
  logic [2:0] pipe_a     [BUTTERFLY_LATENCY];
  logic [2:0] pipe_b     [BUTTERFLY_LATENCY];

  logic [2:0] span;
  logic [2:0] pos;
  logic [2:0] addr_a;
  logic [2:0] addr_b;
  logic [2:0] tw_fwd;
  logic [2:0] tw_code;

  // Butterfly address and twiddle code for the current (s, b).
  always_comb begin
    span   = 3'd1 << s_reg;
    pos    = {1'b0, b_reg} & (span - 3'd1);
    addr_a = (({1'b0, b_reg} >> s_reg) << (s_reg + 2'd1)) | pos;
    addr_b = addr_a + span;
    tw_fwd = pos << (2'd2 - s_reg);
`ifdef FFT_INVERSE_EN
    tw_code = inverse_reg ? (3'd0 - tw_fwd) : tw_fwd;
`else
    tw_code = tw_fwd;
`endif
  end

  // Main FSM; status outputs trail the state by one cycle so busy/done line
  // up with the issue stream. A start seen while done is still visible is
  // treated as part of the DONE cycle and dropped.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg       <= IDLE;
      s_reg           <= 2'd0;
      b_reg           <= 2'd0;
      drain_cnt_reg   <= 3'd0;
`ifdef FFT_INVERSE_EN
      inverse_reg     <= 1'b0;
`endif
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      stage_reg       <= 2'd0;
      issue_valid_reg <= 1'b0;
      rd_a_reg        <= 3'd0;
      rd_b_reg        <= 3'd0;
      tw_reg          <= 3'd0;
    end else begin
      busy_reg        <= (state_reg == ISSUE) || (state_reg == DRAIN);
      done_reg        <= (state_reg == DONE);
      stage_reg       <= s_reg;
      issue_valid_reg <= 1'b0;
      rd_a_reg        <= 3'd0;
      rd_b_reg        <= 3'd0;
      tw_reg          <= 3'd0;
      case (state_reg)
        IDLE: begin
          if (bus.start && !done_reg) begin
            state_reg <= ISSUE;
            s_reg     <= 2'd0;
            b_reg     <= 2'd0;
`ifdef FFT_INVERSE_EN
            inverse_reg <= bus.inverse;
`endif
          end
        end
        ISSUE: begin
          if (!bus.stall) begin
            issue_valid_reg <= 1'b1;
            rd_a_reg        <= addr_a;
            rd_b_reg        <= addr_b;
            tw_reg          <= tw_code;
            b_reg           <= b_reg + 2'd1;
            if (b_reg == 2'd3) begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= 3'd0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            if (s_reg == 2'd2) begin
              state_reg <= DONE;
            end else begin
              s_reg     <= s_reg + 2'd1;
              b_reg     <= 2'd0;
              state_reg <= ISSUE;
            end
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 3'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Write-back delay line; it always advances, stall only gates new issues.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < BUTTERFLY_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_a[i]     <= 3'd0;
        pipe_b[i]     <= 3'd0;
      end
    end else begin
      pipe_valid[0] <= issue_valid_reg;
      pipe_a[0]     <= rd_a_reg;
      pipe_b[0]     <= rd_b_reg;
      for (int i = 1; i < BUTTERFLY_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_a[i]     <= pipe_a[i-1];
        pipe_b[i]     <= pipe_b[i-1];
      end
    end
  end

  assign bus.busy           = busy_reg;
  assign bus.done           = done_reg;
  assign bus.stage          = stage_reg;
  assign bus.issue_valid    = issue_valid_reg;
  assign bus.rd_addr_a      = rd_a_reg;
  assign bus.rd_addr_b      = rd_b_reg;
  assign bus.twiddle_select = tw_reg;
  assign bus.wr_valid       = pipe_valid[BUTTERFLY_LATENCY-1];
  assign bus.wr_addr_a      = pipe_a[BUTTERFLY_LATENCY-1];
  assign bus.wr_addr_b      = pipe_b[BUTTERFLY_LATENCY-1];

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: three instances (L=2, L=1, L=7).
// Stimulus pushes expected issue / write-back / done events; per-instance
// monitors pop and compare whenever the DUT presents them.
module tb_fft_sequencer;
  localparam int NI = 3;

  typedef struct {
    int cyc;
    int stage;
    int a;
    int b;
    int tw;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  logic rst_n_v [NI];
  logic start_v [NI];
  logic stall_v [NI];
`ifdef FFT_INVERSE_EN
  logic inv_v   [NI];
`endif
  logic [20:0] outs [NI];

  ev_t iss_q  [NI][$];
  ev_t wr_q   [NI][$];
  int  done_q [NI][$];

  // Hand-computed issue order, flat index k = stage*4 + butterfly.
  int exp_a      [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_b      [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_tw     [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
  int exp_tw_inv [12] = '{0, 0, 0, 0,  0, 6, 0, 6,  0, 7, 6, 5};

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 7);
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 7);
    fft_sequencer_if bus ();
    assign bus.start = start_v[gi];
    assign bus.stall = stall_v[gi];
`ifdef FFT_INVERSE_EN
    assign bus.inverse = inv_v[gi];
`endif
    assign outs[gi] = {bus.busy, bus.done, bus.stage, bus.issue_valid,
                       bus.rd_addr_a, bus.rd_addr_b, bus.twiddle_select,
                       bus.wr_valid, bus.wr_addr_a, bus.wr_addr_b};

    fft_sequencer #(.BUTTERFLY_LATENCY(LAT)) dut (
      .clk    (clk),
      .nReset (rst_n_v[gi]),
      .bus    (bus)
    );

    // Monitor: compare each presented event against the scoreboard head.
    always @(negedge clk) begin : mon
      ev_t e;
      int  d;
      if (bus.issue_valid === 1'b1) begin
        checks++;
        if (iss_q[gi].size() == 0) begin
          fails++;
          $display("FAIL issue_unexpected inst%0d: got a=%0d b=%0d at cycle %0d, required no issue",
                   gi, bus.rd_addr_a, bus.rd_addr_b, cyc);
        end else begin
          e = iss_q[gi].pop_front();
          if (cyc != e.cyc || int'(bus.stage) != e.stage || int'(bus.rd_addr_a) != e.a ||
              int'(bus.rd_addr_b) != e.b || int'(bus.twiddle_select) != e.tw) begin
            fails++;
            $display("FAIL issue inst%0d: got cyc=%0d stage=%0d a=%0d b=%0d tw=%0d, required cyc=%0d stage=%0d a=%0d b=%0d tw=%0d",
                     gi, cyc, bus.stage, bus.rd_addr_a, bus.rd_addr_b, bus.twiddle_select,
                     e.cyc, e.stage, e.a, e.b, e.tw);
          end
        end
      end
      if (bus.wr_valid === 1'b1) begin
        checks++;
        if (wr_q[gi].size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected inst%0d: got wr a=%0d b=%0d at cycle %0d, required no write",
                   gi, bus.wr_addr_a, bus.wr_addr_b, cyc);
        end else begin
          e = wr_q[gi].pop_front();
          if (cyc != e.cyc || int'(bus.wr_addr_a) != e.a || int'(bus.wr_addr_b) != e.b) begin
            fails++;
            $display("FAIL wr inst%0d: got cyc=%0d a=%0d b=%0d, required cyc=%0d a=%0d b=%0d",
                     gi, cyc, bus.wr_addr_a, bus.wr_addr_b, e.cyc, e.a, e.b);
          end
        end
      end
      if (bus.done === 1'b1) begin
        checks++;
        if (done_q[gi].size() == 0) begin
          fails++;
          $display("FAIL done_unexpected inst%0d: got done at cycle %0d, required none", gi, cyc);
        end else begin
          d = done_q[gi].pop_front();
          if (cyc != d) begin
            fails++;
            $display("FAIL done inst%0d: got cycle %0d, required cycle %0d", gi, cyc, d);
          end
        end
      end
    end
  end

  function automatic void chk(string name, int got, int req);
    checks++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endfunction

  // Push the whole expected event stream of one transform started at t0.
  function automatic void expect_run(int inst, int t0, bit inv, int stall_idx, int stall_len);
    int  lat;
    int  c;
    ev_t e;
    lat = lat_of(inst);
    for (int k = 0; k < 12; k++) begin
      c = t0 + 1 + (k / 4) * (4 + lat) + (k % 4) + ((k >= stall_idx) ? stall_len : 0);
      e.cyc   = c;
      e.stage = k / 4;
      e.a     = exp_a[k];
      e.b     = exp_b[k];
      e.tw    = inv ? exp_tw_inv[k] : exp_tw[k];
      iss_q[inst].push_back(e);
      e.cyc   = c + lat;
      wr_q[inst].push_back(e);
    end
    done_q[inst].push_back(t0 + 3 * (4 + lat) + 1 + stall_len);
  endfunction

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_drained(string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_issue_left_inst%0d", tag, i), iss_q[i].size(), 0);
      chk($sformatf("%s_wr_left_inst%0d", tag, i), wr_q[i].size(), 0);
      chk($sformatf("%s_done_left_inst%0d", tag, i), done_q[i].size(), 0);
    end
  endtask

  initial begin
    int t0;
    for (int i = 0; i < NI; i++) begin
      rst_n_v[i] = 1'b0;
      start_v[i] = 1'b0;
      stall_v[i] = 1'b0;
`ifdef FFT_INVERSE_EN
      inv_v[i] = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("reset_outputs_inst%0d", i), int'(outs[i]), 0);
    for (int i = 0; i < NI; i++) rst_n_v[i] = 1'b1;
    repeat (2) @(negedge clk);

    // Forward run on all latencies; inst0 also sees start during DRAIN/DONE.
    t0 = cyc + 1;
    for (int i = 0; i < NI; i++) expect_run(i, t0, 1'b0, 12, 0);
    for (int i = 0; i < NI; i++) start_v[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
    chk("busy_cycle0_L2", int'(g_dut[0].bus.busy), 0);
    wait_to(t0 + 1);
    chk("busy_cycle1_L2", int'(g_dut[0].bus.busy), 1);
    wait_to(t0 + 5);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_to(t0 + 18);
    chk("busy_cycle18_L2", int'(g_dut[0].bus.busy), 1);
    start_v[0] = 1'b1;
    @(negedge clk);
    chk("busy_cycle19_L2", int'(g_dut[0].bus.busy), 0);
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_to(t0 + 45);
    check_drained("forward");

    // Stall for 3 cycles in front of stage-1 butterfly 2 (L=2).
    t0 = cyc + 1;
    expect_run(0, t0, 1'b0, 6, 3);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_to(t0 + 8);
    stall_v[0] = 1'b1;
    wait_to(t0 + 11);
    stall_v[0] = 1'b0;
    wait_to(t0 + 30);
    check_drained("stall");

    // Reset in the middle of stage 1, then a clean restart.
    t0 = cyc + 1;
    expect_run(0, t0, 1'b0, 12, 0);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_to(t0 + 8);
    #2;
    rst_n_v[0] = 1'b0;
    #1;
    chk("midreset_outputs_now", int'(outs[0]), 0);
    iss_q[0].delete();
    wr_q[0].delete();
    done_q[0].delete();
    repeat (3) @(negedge clk);
    chk("midreset_outputs_held", int'(outs[0]), 0);
    rst_n_v[0] = 1'b1;
    repeat (12) @(negedge clk);
    chk("after_reset_idle_outputs", int'(outs[0]), 0);
    t0 = cyc + 1;
    expect_run(0, t0, 1'b0, 12, 0);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_to(t0 + 30);
    check_drained("restart");

`ifdef FFT_INVERSE_EN
    // Inverse run: the request bit is dropped right after start to show it is latched.
    t0 = cyc + 1;
    expect_run(0, t0, 1'b1, 12, 0);
    inv_v[0]   = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    inv_v[0]   = 1'b0;
    wait_to(t0 + 30);
    check_drained("inverse");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
